tcon_load_arbiter: RTL
======================

Name: tcon_load_arbiter

Overview:
- Sequences the 8-bit select/hold datapath. The datapath is a per-bit 2:1 mux: when the select line is high it takes a new load word, otherwise it takes the held word.
- Shares that single load path between NREQ requesters using round-robin arbitration and a valid/ready handshake.
- Enforces a minimum hold interval after each load so downstream logic sees a stable word.
- Owns the held register; drives the mux select and both mux operands.

Parameters:
- DW, 8, data width of the held word and of each request word.
- NREQ, 4, number of requesters; legal range 2..16.
- HOLD_CYCLES, 2, cycles the word is frozen after a load; legal range 0..255; 0 disables the hold state.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  NREQ  per-requester load request.
- req_data  input  NREQ*DW  packed request words; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; a handshake completes when valid and ready are both high.
- clear  input  1  synchronous clear of the held word.
- sel_o  output  1  mux select; high only in a grant cycle.
- mux_a_o  output  DW  winner's request word; 0 when no grant.
- mux_b_o  output  DW  current held word (hold feedback).
- data_o  output  DW  held word, registered.
- grant_id_o  output  $clog2(NREQ)  index of the last granted requester, registered.
- load_o  output  1  one-cycle pulse, registered; high the cycle after a load.
- busy_o  output  1  high while in HOLD.

Behaviour:
- Reset values:
  - data_o = 0, grant_id_o = 0, load_o = 0, busy_o = 0.
  - state = IDLE, rr_ptr = 0, hold_cnt = 0.
  - Combinational outputs are 0 during reset: req_ready, sel_o, mux_a_o.
- States: IDLE, HOLD.
- IDLE:
  - If clear=0 and any req_valid is high, the winner is the first valid index at or after rr_ptr, searching upward with wrap at NREQ.
  - In the same cycle: req_ready[winner]=1, sel_o=1, mux_a_o=req_data[winner]. Grant latency is 0 cycles.
  - At the clock edge:
    - data_o <= winner word; grant_id_o <= winner; load_o <= 1.
    - rr_ptr <= winner+1, wrapping to 0 after NREQ-1.
    - If HOLD_CYCLES>0: state <= HOLD and hold_cnt <= HOLD_CYCLES. Otherwise stay in IDLE, so back-to-back loads every cycle are allowed.
  - If no valid request: sel_o=0 and data_o holds, i.e. data_o <= mux_b_o.
- HOLD:
  - req_ready=0, sel_o=0, busy_o=1; hold_cnt decrements each cycle.
  - When hold_cnt==1, state <= IDLE at that edge.
  - The first new grant occurs exactly HOLD_CYCLES cycles after the load edge.
  - req_valid asserted during HOLD is ignored but not lost; requesters keep valid asserted until ready.
- Datapath identity: on every edge data_o <= sel_o ? mux_a_o : mux_b_o, unless clear overrides.
- clear:
  - In any state: data_o <= 0, state <= IDLE, hold_cnt <= 0, load_o <= 0.
  - Takes priority over a same-cycle grant: req_ready=0, sel_o=0, rr_ptr unchanged.
- Requester rules:
  - Dropping req_valid without ready is legal (request withdrawn).
  - req_data only needs to be stable in the grant cycle.
- Simultaneous requests: exactly one grant per cycle; the round-robin scheme guarantees no requester waits more than NREQ-1 grants.
- Reset mid-HOLD: returns to IDLE with rr_ptr=0 and data_o=0; the first grant after reset goes to the lowest valid index.
- Width rules:
  - hold_cnt is $clog2(HOLD_CYCLES+1) bits, minimum 1.
  - rr_ptr wraps modulo NREQ, including non-power-of-two NREQ.

Decomposition:
- Package tcon_pkg: state enum {IDLE, HOLD}; default DW=8; function to compute counter width.
- Sub-module rr_arbiter:
  - Inputs: NREQ-wide request vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any-valid flag.
  - Purely combinational; reusable by other load paths.
- The top level holds the FSM, hold counter, held register and output registers.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'hA5 -> same cycle req_ready=4'b0001 and sel_o=1; next cycle data_o=8'hA5, load_o=1, busy_o=1; ready stays 0 for 2 cycles.
- All four valid continuously with data 8'h10..8'h13, HOLD_CYCLES=2 -> grants in order 0,1,2,3,0, spaced every 3 cycles; data_o steps 10,11,12,13,10.
- HOLD_CYCLES=0, requesters 1 and 3 valid -> alternating grants 1,3,1,3 on consecutive cycles; sel_o stays high.
- clear asserted in a grant cycle with data_o=8'h5C -> req_ready=0, next data_o=8'h00, rr_ptr unchanged; the same requester wins next cycle.
- rst asserted during HOLD with hold_cnt=1 -> next cycle all outputs 0 and state IDLE; with req_valid=4'b1100, the first grant goes to index 2.
- Idle for 10 cycles after a load of 8'h3C -> data_o stays 8'h3C, sel_o=0, mux_b_o=8'h3C throughout.

Source files
------------

// File: rtl/tcon_load_arbiter_pkg.sv
// Shared types and helpers for the select/hold load arbiter.
package tcon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DW_DEFAULT = 8;

    // Hold counter must represent HOLD_CYCLES and never collapse to zero bits.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tcon_load_arbiter_if.sv
// Request bundle shared by all requesters and the load arbiter.
interface tcon_load_arbiter_if #(
    parameter int DW   = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/tcon_load_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Modulo in integer arithmetic keeps non-power-of-two NREQ correct.
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcon_load_arbiter.sv
// Round-robin sharing of one select/hold load path, with a minimum hold after each load.
module tcon_load_arbiter
    import tcon_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int IW          = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    tcon_load_arbiter_if.slave     req_if,
    input  logic                   clear,
    output logic                   sel_o,
    output logic [DW-1:0]          mux_a_o,
    output logic [DW-1:0]          mux_b_o,
    output logic [DW-1:0]          data_o,
    output logic [IW-1:0]          grant_id_o,
    output logic                   load_o,
    output logic                   busy_o
);

    localparam int CW = cnt_w(HOLD_CYCLES);

    state_e          state_q, state_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            load_q, load_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            grant;
    logic [DW-1:0]   win_word;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i (req_if.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Clear and reset both veto the grant so no handshake completes in that cycle.
    assign grant = !rst && !clear && (state_q == IDLE) && arb_any;

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                win_word = req_if.req_data[i*DW +: DW];
            end
        end
    end

    assign req_if.req_ready = grant ? arb_gnt : '0;
    assign sel_o            = grant;
    assign mux_a_o          = grant ? win_word : '0;
    assign mux_b_o          = data_q;
    assign data_o           = data_q;
    assign grant_id_o       = grant_id_q;
    assign load_o           = load_q;
    assign busy_o           = (state_q == HOLD);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        data_d     = sel_o ? mux_a_o : mux_b_o;
        grant_id_d = grant_id_q;
        load_d     = grant;
        if (clear) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            data_d     = '0;
            load_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        grant_id_d = arb_idx;
                        rr_ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                        if (HOLD_CYCLES > 0) begin
                            state_d    = HOLD;
                            hold_cnt_d = CW'(HOLD_CYCLES);
                        end
                    end
                end
                HOLD: begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (hold_cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rr_ptr_q   <= '0;
            data_q     <= '0;
            grant_id_q <= '0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            load_q     <= load_d;
        end
    end

endmodule
